// File: rtl/blit_pkg.sv
// Shared state encoding, width helper and default colour key for the sprite blitter.
package blit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } blit_state_e;

    localparam logic [8:0] TRANSPARENT_KEY_DEFAULT = 9'h1FF;

    // Width of a counter/bus able to index n items; never returns 0 so ports stay legal.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/blit_raster_ctr.sv
// Raster-order pixel counter across one sprite tile: px runs fastest, py advances on px wrap.
module blit_raster_ctr
    import blit_pkg::*;
#(
    parameter int TILE_W = 20,
    parameter int TILE_H = 20
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          clear,
    input  logic                          enable,
    output logic [clog2_safe(TILE_W)-1:0] px,
    output logic [clog2_safe(TILE_H)-1:0] py,
    output logic                          last
);

    localparam int PX_W = clog2_safe(TILE_W);
    localparam int PY_W = clog2_safe(TILE_H);
    localparam logic [PX_W-1:0] PX_MAX = PX_W'(TILE_W - 1);
    localparam logic [PY_W-1:0] PY_MAX = PY_W'(TILE_H - 1);

    logic [PX_W-1:0] px_q, px_d;
    logic [PY_W-1:0] py_q, py_d;

    // NOTE: every variable written here gets a default first, so no path leaves a latch.
    always_comb begin
        px_d = px_q;
        py_d = py_q;
        if (clear) begin
            px_d = '0;
            py_d = '0;
        end else if (enable) begin
            if (px_q == PX_MAX) begin
                px_d = '0;
                py_d = (py_q == PY_MAX) ? '0 : py_q + 1'b1;
            end else begin
                px_d = px_q + 1'b1;
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            px_q <= '0;
            py_q <= '0;
        end else begin
            px_q <= px_d;
            py_q <= py_d;
        end
    end

    assign px   = px_q;
    assign py   = py_q;
    assign last = (px_q == PX_MAX) && (py_q == PY_MAX);

endmodule

// File: rtl/sprite_blitter.sv
// Streams one TILE_W x TILE_H sprite from an external ROM to the VGA adapter with screen clipping.
// Define BLIT_TRANSPARENCY_EN to suppress plots of pixels whose colour equals TRANSPARENT_KEY.
module sprite_blitter
    import blit_pkg::*;
#(
    parameter int TILE_W      = 20,
    parameter int TILE_H      = 20,
    parameter int GRID_W      = 4,
    parameter int SCREEN_W    = 160,
    parameter int SCREEN_H    = 120,
    parameter int COLOUR_W    = 9,
    parameter int NUM_SPRITES = 4,
    parameter int ROM_LAT     = 1
`ifdef BLIT_TRANSPARENCY_EN
    ,
    parameter logic [COLOUR_W-1:0] TRANSPARENT_KEY = COLOUR_W'(TRANSPARENT_KEY_DEFAULT)
`endif
) (
    input  logic                                              clk,
    input  logic                                              resetn,
    input  logic                                              start,
    input  logic [clog2_safe(NUM_SPRITES)-1:0]                sprite_sel,
    input  logic [GRID_W-1:0]                                 grid_x,
    input  logic [GRID_W-1:0]                                 grid_y,
    output logic                                              busy,
    output logic                                              done,
    output logic [clog2_safe(NUM_SPRITES*TILE_W*TILE_H)-1:0]  rom_addr,
    input  logic [COLOUR_W-1:0]                               rom_q,
    output logic [clog2_safe(SCREEN_W)-1:0]                   x,
    output logic [clog2_safe(SCREEN_H)-1:0]                   y,
    output logic [COLOUR_W-1:0]                               colour,
    output logic                                              plot,
    output logic [clog2_safe(SCREEN_W*SCREEN_H)-1:0]          map_mem_add
);

    localparam int SEL_W  = clog2_safe(NUM_SPRITES);
    localparam int ADDR_W = clog2_safe(NUM_SPRITES * TILE_W * TILE_H);
    localparam int X_W    = clog2_safe(SCREEN_W);
    localparam int Y_W    = clog2_safe(SCREEN_H);
    localparam int MAP_W  = clog2_safe(SCREEN_W * SCREEN_H);
    localparam int PX_W   = clog2_safe(TILE_W);
    localparam int PY_W   = clog2_safe(TILE_H);
    localparam int DRN_W  = clog2_safe(ROM_LAT + 1);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(ROM_LAT);

    // Control state
    blit_state_e      state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [GRID_W-1:0] gx_q, gx_d;
    logic [GRID_W-1:0] gy_q, gy_d;
    logic [DRN_W-1:0] drn_q, drn_d;

    // Raster counter interface
    logic            ctr_clear;
    logic            ctr_enable;
    logic            ctr_last;
    logic [PX_W-1:0] px;
    logic [PY_W-1:0] py;

    // Address-tracking pipeline, one stage per cycle of ROM latency
    logic            vld_q    [ROM_LAT];
    logic            vld_d    [ROM_LAT];
    logic [PX_W-1:0] px_pipe_q[ROM_LAT];
    logic [PX_W-1:0] px_pipe_d[ROM_LAT];
    logic [PY_W-1:0] py_pipe_q[ROM_LAT];
    logic [PY_W-1:0] py_pipe_d[ROM_LAT];

    // Pixel output register
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic                plot_q, plot_d;

    logic [31:0] x_full;
    logic [31:0] y_full;
    logic        in_screen;
    logic        opaque;

    blit_raster_ctr #(
        .TILE_W (TILE_W),
        .TILE_H (TILE_H)
    ) u_raster_ctr (
        .clk    (clk),
        .resetn (resetn),
        .clear  (ctr_clear),
        .enable (ctr_enable),
        .px     (px),
        .py     (py),
        .last   (ctr_last)
    );

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sel_d      = sel_q;
        gx_d       = gx_q;
        gy_d       = gy_q;
        drn_d      = drn_q;
        ctr_clear  = 1'b0;
        ctr_enable = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
                if (start) begin
                    state_d   = FETCH;
                    busy_d    = 1'b1;
                    sel_d     = sprite_sel;
                    gx_d      = grid_x;
                    gy_d      = grid_y;
                    ctr_clear = 1'b1;
                end
            end
            FETCH: begin
                ctr_enable = 1'b1;
                if (ctr_last) begin
                    state_d = DRAIN;
                    drn_d   = '0;
                end
            end
            DRAIN: begin
                // ROM_LAT cycles empty the address pipeline, one more lets the final pixel leave the output register.
                if (drn_q == DRN_LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    drn_d = drn_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sel_q   <= '0;
            gx_q    <= '0;
            gy_q    <= '0;
            drn_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sel_q   <= sel_d;
            gx_q    <= gx_d;
            gy_q    <= gy_d;
            drn_q   <= drn_d;
        end
    end

    assign rom_addr = ADDR_W'(32'(sel_q) * (TILE_W * TILE_H) + 32'(py) * TILE_W + 32'(px));

    always_comb begin
        vld_d[0]     = (state_q == FETCH);
        px_pipe_d[0] = px;
        py_pipe_d[0] = py;
        for (int i = 1; i < ROM_LAT; i++) begin
            vld_d[i]     = vld_q[i-1];
            px_pipe_d[i] = px_pipe_q[i-1];
            py_pipe_d[i] = py_pipe_q[i-1];
        end
    end

    // Screen position is formed at full width so off-screen tiles clip instead of wrapping.
    always_comb begin
        x_full    = 32'(gx_q) * TILE_W + 32'(px_pipe_q[ROM_LAT-1]);
        y_full    = 32'(gy_q) * TILE_H + 32'(py_pipe_q[ROM_LAT-1]);
        in_screen = (x_full < SCREEN_W) && (y_full < SCREEN_H);
`ifdef BLIT_TRANSPARENCY_EN
        opaque    = (rom_q != TRANSPARENT_KEY);
`else
        opaque    = 1'b1;
`endif
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = vld_q[ROM_LAT-1] && in_screen && opaque;
        if (vld_q[ROM_LAT-1]) begin
            x_d      = X_W'(x_full);
            y_d      = Y_W'(y_full);
            colour_d = rom_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: the pipeline arrays are plain flops, so they are reset like any other register.
            for (int i = 0; i < ROM_LAT; i++) begin
                vld_q[i]     <= 1'b0;
                px_pipe_q[i] <= '0;
                py_pipe_q[i] <= '0;
            end
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
        end else begin
            for (int i = 0; i < ROM_LAT; i++) begin
                vld_q[i]     <= vld_d[i];
                px_pipe_q[i] <= px_pipe_d[i];
                py_pipe_q[i] <= py_pipe_d[i];
            end
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign x           = x_q;
    assign y           = y_q;
    assign colour      = colour_q;
    assign plot        = plot_q;
    assign map_mem_add = MAP_W'(32'(y_q) * SCREEN_W + 32'(x_q));

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: a tile-level model schedules expected outputs per cycle.
module tb_sprite_blitter;

    localparam int TILE_W   = 20;
    localparam int TILE_H   = 20;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int NPIX     = TILE_W * TILE_H;
`ifdef BLIT_TRANSPARENCY_EN
    localparam int LAT   = 3;
    localparam bit TRANS = 1'b1;
`else
    localparam int LAT   = 1;
    localparam bit TRANS = 1'b0;
`endif
    localparam logic [8:0] KEY = 9'h1FF;
    localparam int DONE_DLY = (LAT == 1) ? 402 : 404;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  sprite_sel = '0;
    logic [3:0]  grid_x = '0;
    logic [3:0]  grid_y = '0;
    logic        busy, done, plot;
    logic [10:0] rom_addr;
    logic [8:0]  rom_q, colour;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [14:0] map_mem_add;

    sprite_blitter #(
        .ROM_LAT (LAT)
`ifdef BLIT_TRANSPARENCY_EN
        , .TRANSPARENT_KEY (KEY)
`endif
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .sprite_sel  (sprite_sel),
        .grid_x      (grid_x),
        .grid_y      (grid_y),
        .busy        (busy),
        .done        (done),
        .rom_addr    (rom_addr),
        .rom_q       (rom_q),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .plot        (plot),
        .map_mem_add (map_mem_add)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM content: sprite 2 begins with 50 key-coloured pixels; otherwise q = addr[8:0] with the key value avoided.
    function automatic logic [8:0] rom_val(input int addr);
        logic [8:0] low;
        low = addr[8:0];
        if (addr >= 800 && addr < 850) return KEY;
        if (low == KEY) return 9'h000;
        return low;
    endfunction

    logic [8:0] rom_pipe [LAT];
    always @(posedge clk) begin
        rom_pipe[0] <= rom_val(int'(rom_addr));
        for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_q = rom_pipe[LAT-1];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Model: expected outputs keyed by the cycle index (number of rising edges seen).
    bit exp_plot[int];
    int exp_x[int];
    int exp_y[int];
    int exp_col[int];
    int exp_addr[int];
    bit exp_done[int];
    bit exp_busy[int];

    task automatic schedule_draw(input int a, input int sel, input int gx, input int gy);
        for (int k = 0; k < NPIX; k++) begin
            int px, py, xf, yf, addr, c;
            px   = k % TILE_W;
            py   = k / TILE_W;
            xf   = gx * TILE_W + px;
            yf   = gy * TILE_H + py;
            addr = sel * NPIX + k;
            c    = a + k + LAT + 1;
            exp_addr[a + k] = addr;
            exp_plot[c] = (xf < SCREEN_W) && (yf < SCREEN_H) && !(TRANS && rom_val(addr) == KEY);
            exp_x[c]    = xf % 256;
            exp_y[c]    = yf % 128;
            exp_col[c]  = int'(rom_val(addr));
        end
        for (int c = a; c <= a + NPIX + LAT + 1; c++) exp_busy[c] = 1'b1;
        exp_done[a + NPIX + LAT + 1] = 1'b1;
    endtask

    task automatic clear_model();
        exp_plot.delete(); exp_x.delete(); exp_y.delete(); exp_col.delete();
        exp_addr.delete(); exp_done.delete(); exp_busy.delete();
    endtask

    bit check_en = 1'b0;
    int plot_cnt, done_cnt, busy_cnt, done_cyc;
    bit first_seen;
    int first_x, first_y, first_col, first_map, last_x, last_y, last_col, last_map;
    int c_now;
    bit e_plot;

    task automatic clear_stats();
        plot_cnt = 0; done_cnt = 0; busy_cnt = 0; done_cyc = -1; first_seen = 1'b0;
        first_x = -1; first_y = -1; first_col = -1; first_map = -1;
        last_x = -1; last_y = -1; last_col = -1; last_map = -1;
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            c_now  = cyc;
            e_plot = exp_plot.exists(c_now) ? exp_plot[c_now] : 1'b0;
            check("plot", plot, e_plot);
            if (exp_x.exists(c_now)) begin
                check("x", x, exp_x[c_now]);
                check("y", y, exp_y[c_now]);
                check("colour", colour, exp_col[c_now]);
                check("map_mem_add", map_mem_add, (exp_y[c_now] * SCREEN_W + exp_x[c_now]) % 32768);
            end
            check("done", done, exp_done.exists(c_now));
            check("busy", busy, exp_busy.exists(c_now));
            if (exp_addr.exists(c_now)) check("rom_addr", rom_addr, exp_addr[c_now]);
            if (plot === 1'b1) begin
                plot_cnt++;
                if (!first_seen) begin
                    first_seen = 1'b1;
                    first_x = int'(x); first_y = int'(y); first_col = int'(colour); first_map = int'(map_mem_add);
                end
                last_x = int'(x); last_y = int'(y); last_col = int'(colour); last_map = int'(map_mem_add);
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = c_now;
            end
            if (busy === 1'b1) busy_cnt++;
        end
    end

    // Called on a falling edge; the next rising edge accepts. Inputs are scrambled afterwards.
    task automatic start_draw(input int sel, input int gx, input int gy, output int a);
        sprite_sel = 2'(sel);
        grid_x     = 4'(gx);
        grid_y     = 4'(gy);
        start      = 1'b1;
        a          = cyc + 1;
        schedule_draw(a, sel, gx, gy);
        @(negedge clk);
        start      = 1'b0;
        sprite_sel = 2'(sel + 1);
        grid_x     = 4'(gx + 3);
        grid_y     = 4'(gy + 5);
    endtask

    task automatic finish_draw(input int a);
        while (cyc < a + NPIX + LAT + 3) @(negedge clk);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_plot"}, plot, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_x"}, x, 0);
        check({tag, "_y"}, y, 0);
        check({tag, "_colour"}, colour, 0);
        check({tag, "_rom_addr"}, rom_addr, 0);
        check({tag, "_map"}, map_mem_add, 0);
    endtask

    initial begin
        int a, a2;
        clear_stats();
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        resetn   = 1'b1;
        check_en = 1'b1;
        repeat (2) @(negedge clk);

        // 1: sprite 0 at the origin
        clear_stats();
        start_draw(0, 0, 0, a);
        finish_draw(a);
        check("t1_plots", plot_cnt, 400);
        check("t1_first_x", first_x, 0);
        check("t1_first_y", first_y, 0);
        check("t1_first_col", first_col, 0);
        check("t1_last_x", last_x, 19);
        check("t1_last_y", last_y, 19);
        check("t1_last_col", last_col, 399);
        check("t1_done_dly", done_cyc - a, DONE_DLY);

        // 2: bottom-right tile touching both screen edges
        clear_stats();
        start_draw(0, 7, 5, a);
        finish_draw(a);
        check("t2_plots", plot_cnt, 400);
        check("t2_first_xy", first_x * 1000 + first_y, 140100);
        check("t2_last_xy", last_x * 1000 + last_y, 159119);
        check("t2_first_map", first_map, 16140);
        check("t2_last_map", last_map, 19199);

        // 3: fully off-screen tile
        clear_stats();
        start_draw(1, 8, 6, a);
        finish_draw(a);
        check("t3_plots", plot_cnt, 0);
        check("t3_done_dly", done_cyc - a, DONE_DLY);

        // 4: start held high across two draws, then ignored pulses mid-FETCH
        clear_stats();
        sprite_sel = 2'd1;
        grid_x     = 4'd1;
        grid_y     = 4'd1;
        start      = 1'b1;
        a          = cyc + 1;
        schedule_draw(a, 1, 1, 1);
        while (cyc < a + NPIX + LAT + 1) @(negedge clk);
        a2 = cyc + 1;
        schedule_draw(a2, 1, 1, 1);
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        grid_x = 4'd3;
        grid_y = 4'd3;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        repeat (100) @(negedge clk);
        sprite_sel = 2'd3;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        finish_draw(a2);
        check("t4_second_accept", a2 - a, DONE_DLY + 1);
        check("t4_plots", plot_cnt, 800);
        check("t4_dones", done_cnt, 2);
        check("t4_busy_cycles", busy_cnt, (LAT == 1) ? 806 : 810);

        // 5: reset mid-draw abandons it; a fresh draw then runs normally
        clear_stats();
        start_draw(0, 2, 2, a);
        while (cyc < a + 150) @(negedge clk);
        resetn   = 1'b0;
        check_en = 1'b0;
        clear_model();
        #1;
        check_zero_outputs("t5_async");
        repeat (3) begin
            @(negedge clk);
            check_zero_outputs("t5_hold");
        end
        resetn   = 1'b1;
        check_en = 1'b1;
        clear_stats();
        repeat (20) @(negedge clk);
        check("t5_no_done", done_cnt, 0);
        start_draw(0, 0, 0, a);
        finish_draw(a);
        check("t5_plots", plot_cnt, 400);
        check("t5_done_dly", done_cyc - a, DONE_DLY);

        // 6: sprite 2, whose first 50 pixels carry the key colour
        clear_stats();
        start_draw(2, 0, 0, a);
        check("t6_addr0", rom_addr, 800);
        finish_draw(a);
        check("t6_plots", plot_cnt, TRANS ? 350 : 400);
        check("t6_done_dly", done_cyc - a, DONE_DLY);

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
